// File: rtl/mt_regfile_pkg.sv
// ----------------------------------------------------------------------------
// mt_regfile_pkg
// Shared definitions for the multi-threaded register file:
//   seq_state_t : sequencer states (INIT, IDLE, CLEAR)
//   REG_COUNT   : architectural registers per thread context
//   REG_AW      : register address width
// ----------------------------------------------------------------------------
package mt_regfile_pkg;

    localparam int REG_COUNT = 32;
    localparam int REG_AW    = 5;

    typedef enum logic [1:0] {
        INIT  = 2'd0,   // zeroing every entry of every thread after reset
        IDLE  = 2'd1,   // normal operation
        CLEAR = 2'd2    // zeroing registers 1..31 of one thread
    } seq_state_t;

endpackage

// File: rtl/mt_regfile_seq.sv
// ----------------------------------------------------------------------------
// mt_regfile_seq
// Context sequencer. It walks all N_THREADS*32 entries after reset (INIT),
// then on request zeroes registers 1..31 of a single thread (CLEAR). It
// produces the zeroing write address/enable and the masking status the
// register file uses.
//
// Ports
//   clk, reset   : clock, synchronous active-high reset
//   clr_req      : request to clear one thread context (honoured in IDLE)
//   clr_tid      : thread to clear, latched on acceptance
//   seq_we       : zeroing write enable
//   seq_addr     : zeroing write address {thread, reg}
//   init_active  : INIT in progress (all reads masked, all WB writes dropped)
//   clear_active : CLEAR in progress
//   clear_tid    : thread being cleared (valid while clear_active)
//   ready        : initial clear complete
//   clr_busy     : thread clear in progress
// ----------------------------------------------------------------------------
module mt_regfile_seq
    import mt_regfile_pkg::*;
#(
    parameter int N_THREADS = 4,
    parameter int TID_W     = $clog2(N_THREADS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr_req,
    input  logic [TID_W-1:0]        clr_tid,
    output logic                    seq_we,
    output logic [TID_W+REG_AW-1:0] seq_addr,
    output logic                    init_active,
    output logic                    clear_active,
    output logic [TID_W-1:0]        clear_tid,
    output logic                    ready,
    output logic                    clr_busy
);

    localparam int            AW       = TID_W + REG_AW;
    localparam logic [AW-1:0] LAST_ENT = AW'(N_THREADS * REG_COUNT - 1);
    localparam logic [REG_AW-1:0] LAST_REG = REG_AW'(REG_COUNT - 1);

    seq_state_t        state, state_next;
    logic [AW-1:0]     cnt, cnt_next;
    logic [TID_W-1:0]  tid_q, tid_next;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
            cnt   <= '0;
            tid_q <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            tid_q <= tid_next;
        end
    end

    // NOTE: every output of this block is given a default before the case
    // statement; a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        tid_next   = tid_q;
        seq_we     = 1'b0;
        seq_addr   = '0;
        case (state)
            INIT: begin
                // Flat walk over {thread, reg}: one entry per cycle.
                seq_we   = 1'b1;
                seq_addr = cnt;
                if (cnt == LAST_ENT) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + AW'(1);
                end
            end
            IDLE: begin
                if (clr_req) begin
                    state_next = CLEAR;
                    tid_next   = clr_tid;
                    // x0 is hardwired to zero, so the walk starts at x1.
                    cnt_next   = AW'(1);
                end
            end
            CLEAR: begin
                // clr_req is deliberately not looked at here.
                seq_we   = 1'b1;
                seq_addr = {tid_q, cnt[REG_AW-1:0]};
                if (cnt[REG_AW-1:0] == LAST_REG) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + AW'(1);
                end
            end
            default: begin
                state_next = INIT;
                cnt_next   = '0;
            end
        endcase
    end

    assign init_active  = (state == INIT);
    assign clear_active = (state == CLEAR);
    assign clear_tid    = tid_q;
    assign ready        = (state != INIT);
    assign clr_busy     = (state == CLEAR);

endmodule

// File: rtl/mt_regfile.sv
// ----------------------------------------------------------------------------
// mt_regfile
// Multi-threaded register file: N_THREADS contexts of 32 x D_WIDTH registers,
// two registered read ports, one write-back port, and a sequencer that zeroes
// all contexts after reset and one context on request.
//
// Build option: define MT_REGFILE_BYPASS_EN for write-first behaviour on a
// same-cycle write/read hit; by default a hit returns the pre-write value.
//
// Ports
//   clk, reset         : clock, synchronous active-high reset
//   rd_en_ID           : read request; rs*_data hold while low
//   thread_id_ID       : read thread
//   rs1_ID, rs2_ID     : read addresses
//   rs1_data, rs2_data : registered read data (1-cycle latency)
//   ctrl_WB            : write enable
//   thread_id_WB       : write thread
//   reg_wraddr         : write address (x0 writes are discarded)
//   data_WB            : write data
//   clr_req, clr_tid   : request to zero the context of clr_tid
//   clr_busy           : thread clear in progress
//   ready              : initial clear complete
// ----------------------------------------------------------------------------
module mt_regfile
    import mt_regfile_pkg::*;
#(
    parameter int D_WIDTH   = 64,
    parameter int N_THREADS = 4,
    parameter int TID_W     = $clog2(N_THREADS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rd_en_ID,
    input  logic [TID_W-1:0]   thread_id_ID,
    input  logic [REG_AW-1:0]  rs1_ID,
    input  logic [REG_AW-1:0]  rs2_ID,
    output logic [D_WIDTH-1:0] rs1_data,
    output logic [D_WIDTH-1:0] rs2_data,
    input  logic               ctrl_WB,
    input  logic [TID_W-1:0]   thread_id_WB,
    input  logic [REG_AW-1:0]  reg_wraddr,
    input  logic [D_WIDTH-1:0] data_WB,
    input  logic               clr_req,
    input  logic [TID_W-1:0]   clr_tid,
    output logic               clr_busy,
    output logic               ready
);

    localparam int AW    = TID_W + REG_AW;
    localparam int DEPTH = N_THREADS * REG_COUNT;

    logic             seq_we;
    logic [AW-1:0]    seq_addr;
    logic             init_active;
    logic             clear_active;
    logic [TID_W-1:0] clear_tid;

    mt_regfile_seq #(
        .N_THREADS (N_THREADS),
        .TID_W     (TID_W)
    ) u_seq (
        .clk          (clk),
        .reset        (reset),
        .clr_req      (clr_req),
        .clr_tid      (clr_tid),
        .seq_we       (seq_we),
        .seq_addr     (seq_addr),
        .init_active  (init_active),
        .clear_active (clear_active),
        .clear_tid    (clear_tid),
        .ready        (ready),
        .clr_busy     (clr_busy)
    );

    logic [D_WIDTH-1:0] mem [DEPTH];

    // A WB write is dropped for x0, during INIT, and for the thread being
    // cleared; writes to other threads proceed alongside a CLEAR.
    logic          wb_ok;
    logic [AW-1:0] wb_addr;

    assign wb_addr = {thread_id_WB, reg_wraddr};
    assign wb_ok   = ctrl_WB
                  && (reg_wraddr != '0)
                  && !init_active
                  && !(clear_active && (thread_id_WB == clear_tid));

    // NOTE: the storage array has no reset; the INIT walk defines its
    // contents, which keeps it mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (wb_ok) begin
            mem[wb_addr] <= data_WB;
        end
        // Issued last so a sequencer write wins any address collision.
        if (seq_we) begin
            mem[seq_addr] <= '0;
        end
    end

    // Read path: raw array value, optional bypass, then masking last so
    // x0 / INIT / CLEAR zeroing overrides the bypassed data.
    logic [AW-1:0]      rd1_idx, rd2_idx;
    logic               rd_masked;
    logic [D_WIDTH-1:0] rs1_next, rs2_next;

    assign rd1_idx   = {thread_id_ID, rs1_ID};
    assign rd2_idx   = {thread_id_ID, rs2_ID};
    assign rd_masked = init_active || (clear_active && (thread_id_ID == clear_tid));

    always_comb begin
        rs1_next = mem[rd1_idx];
        rs2_next = mem[rd2_idx];
`ifdef MT_REGFILE_BYPASS_EN
        if (wb_ok && (wb_addr == rd1_idx)) begin
            rs1_next = data_WB;
        end
        if (wb_ok && (wb_addr == rd2_idx)) begin
            rs2_next = data_WB;
        end
`else
        // Read-first: the array value sampled at the edge is the pre-write
        // value, so a same-cycle hit needs no special handling.
`endif
        if (rd_masked || (rs1_ID == '0)) begin
            rs1_next = '0;
        end
        if (rd_masked || (rs2_ID == '0)) begin
            rs2_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rs1_data <= '0;
            rs2_data <= '0;
        end else if (rd_en_ID) begin
            rs1_data <= rs1_next;
            rs2_data <= rs2_next;
        end
    end

endmodule

// File: tb/tb_mt_regfile.sv
// ----------------------------------------------------------------------------
// tb_mt_regfile
// Directed testbench for mt_regfile (D_WIDTH=64, N_THREADS=4). Inputs are
// driven 1 time unit after each rising edge; outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_mt_regfile;

    logic        clk;
    logic        reset;
    logic        rd_en_ID;
    logic [1:0]  thread_id_ID;
    logic [4:0]  rs1_ID;
    logic [4:0]  rs2_ID;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        ctrl_WB;
    logic [1:0]  thread_id_WB;
    logic [4:0]  reg_wraddr;
    logic [63:0] data_WB;
    logic        clr_req;
    logic [1:0]  clr_tid;
    logic        clr_busy;
    logic        ready;

    int tests_run;
    int tests_failed;
    int busy_cycles;

`ifdef MT_REGFILE_BYPASS_EN
    localparam logic [63:0] HIT_EXP = 64'h2;
`else
    localparam logic [63:0] HIT_EXP = 64'h1;
`endif

    mt_regfile #(
        .D_WIDTH   (64),
        .N_THREADS (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rd_en_ID     (rd_en_ID),
        .thread_id_ID (thread_id_ID),
        .rs1_ID       (rs1_ID),
        .rs2_ID       (rs2_ID),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .ctrl_WB      (ctrl_WB),
        .thread_id_WB (thread_id_WB),
        .reg_wraddr   (reg_wraddr),
        .data_WB      (data_WB),
        .clr_req      (clr_req),
        .clr_tid      (clr_tid),
        .clr_busy     (clr_busy),
        .ready        (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic do_read(input logic [1:0] tid, input logic [4:0] a1,
                           input logic [4:0] a2);
        rd_en_ID     = 1'b1;
        thread_id_ID = tid;
        rs1_ID       = a1;
        rs2_ID       = a2;
        tick();
        rd_en_ID     = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] tid, input logic [4:0] addr,
                            input logic [63:0] data);
        ctrl_WB      = 1'b1;
        thread_id_WB = tid;
        reg_wraddr   = addr;
        data_WB      = data;
        tick();
        ctrl_WB      = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        busy_cycles  = 0;
        reset        = 1'b1;
        rd_en_ID     = 1'b0;
        thread_id_ID = '0;
        rs1_ID       = '0;
        rs2_ID       = '0;
        ctrl_WB      = 1'b0;
        thread_id_WB = '0;
        reg_wraddr   = '0;
        data_WB      = '0;
        clr_req      = 1'b0;
        clr_tid      = '0;

        // ---- reset state
        tick();
        tick();
        check("reset_rs1", rs1_data, 64'h0);
        check("reset_rs2", rs2_data, 64'h0);
        check("reset_ready", {63'b0, ready}, 64'h0);
        check("reset_busy", {63'b0, clr_busy}, 64'h0);

        // ---- INIT: 128 cycles; writes ignored, reads return 0
        reset        = 1'b0;
        rd_en_ID     = 1'b1;
        thread_id_ID = 2'd1;
        rs1_ID       = 5'd3;
        rs2_ID       = 5'd5;
        ctrl_WB      = 1'b1;
        thread_id_WB = 2'd1;
        reg_wraddr   = 5'd3;
        data_WB      = 64'h99;
        for (int i = 0; i < 127; i++) tick();
        check("init_ready_127", {63'b0, ready}, 64'h0);
        check("init_read_rs1", rs1_data, 64'h0);
        tick();
        check("init_ready_128", {63'b0, ready}, 64'h1);
        ctrl_WB  = 1'b0;
        rd_en_ID = 1'b0;
        do_read(2'd1, 5'd3, 5'd31);
        check("init_write_ignored", rs1_data, 64'h0);
        check("post_init_zero", rs2_data, 64'h0);

        // ---- basic write / read, thread isolation
        do_write(2'd2, 5'd5, 64'hDEAD);
        do_read(2'd2, 5'd5, 5'd0);
        check("t2_x5", rs1_data, 64'hDEAD);
        check("t2_x0", rs2_data, 64'h0);
        do_read(2'd0, 5'd5, 5'd5);
        check("t0_x5", rs1_data, 64'h0);

        // ---- hold while rd_en_ID=0
        do_read(2'd2, 5'd5, 5'd5);
        thread_id_ID = 2'd0;
        rs1_ID       = 5'd1;
        rs2_ID       = 5'd0;
        tick();
        tick();
        check("hold_rs1", rs1_data, 64'hDEAD);
        check("hold_rs2", rs2_data, 64'hDEAD);

        // ---- x0 write discarded
        do_write(2'd0, 5'd0, 64'h55);
        do_read(2'd0, 5'd0, 5'd0);
        check("x0_write", rs1_data, 64'h0);

        // ---- same-cycle write/read hit
        do_write(2'd1, 5'd7, 64'h1);
        ctrl_WB      = 1'b1;
        thread_id_WB = 2'd1;
        reg_wraddr   = 5'd7;
        data_WB      = 64'h2;
        do_read(2'd1, 5'd7, 5'd7);
        ctrl_WB      = 1'b0;
        check("hit_rs1", rs1_data, HIT_EXP);
        check("hit_rs2", rs2_data, HIT_EXP);
        do_read(2'd1, 5'd7, 5'd7);
        check("hit_after", rs1_data, 64'h2);

        // ---- x0 masking overrides bypass
        ctrl_WB      = 1'b1;
        thread_id_WB = 2'd1;
        reg_wraddr   = 5'd0;
        data_WB      = 64'h77;
        do_read(2'd1, 5'd0, 5'd0);
        ctrl_WB      = 1'b0;
        check("x0_hit", rs1_data, 64'h0);

        // ---- fill every register with 0xFF
        for (int t = 0; t < 4; t++) begin
            for (int a = 1; a < 32; a++) begin
                do_write(2'(t), 5'(a), 64'hFF);
            end
        end
        do_read(2'd3, 5'd31, 5'd1);
        check("fill_t3", rs1_data, 64'hFF);
        do_read(2'd0, 5'd1, 5'd9);
        check("fill_t0", rs1_data, 64'hFF);

        // ---- CLEAR of thread 3
        clr_req = 1'b1;
        clr_tid = 2'd3;
        tick();
        if (clr_busy) busy_cycles++;
        // Ignored request, write to another thread, masked read of thread 3.
        clr_tid      = 2'd0;
        ctrl_WB      = 1'b1;
        thread_id_WB = 2'd0;
        reg_wraddr   = 5'd9;
        data_WB      = 64'h1234;
        do_read(2'd3, 5'd31, 5'd30);
        ctrl_WB      = 1'b0;
        clr_req      = 1'b0;
        if (clr_busy) busy_cycles++;
        check("clear_read_masked", rs1_data, 64'h0);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (clr_busy) busy_cycles++;
        end
        // x4 of thread 3 has already been zeroed; this write must be dropped.
        do_write(2'd3, 5'd4, 64'hABCD);
        if (clr_busy) busy_cycles++;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (clr_busy) busy_cycles++;
        end
        tick();
        if (clr_busy) busy_cycles++;
        check("clear_busy_cycles", 64'(busy_cycles), 64'd31);
        check("clear_busy_low", {63'b0, clr_busy}, 64'h0);
        do_read(2'd3, 5'd31, 5'd1);
        check("t3_x31_cleared", rs1_data, 64'h0);
        check("t3_x1_cleared", rs2_data, 64'h0);
        do_read(2'd3, 5'd4, 5'd4);
        check("t3_x4_write_dropped", rs1_data, 64'h0);
        do_read(2'd0, 5'd1, 5'd9);
        check("t0_x1_kept", rs1_data, 64'hFF);
        check("t0_x9_written", rs2_data, 64'h1234);
        do_read(2'd1, 5'd7, 5'd31);
        check("t1_x7_kept", rs1_data, 64'hFF);
        check("ready_after_clear", {63'b0, ready}, 64'h1);

        // ---- reset in the middle of CLEAR
        clr_req = 1'b1;
        clr_tid = 2'd2;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("clear2_busy", {63'b0, clr_busy}, 64'h1);
        reset = 1'b1;
        tick();
        check("abort_busy", {63'b0, clr_busy}, 64'h0);
        check("abort_ready", {63'b0, ready}, 64'h0);
        check("abort_rs1", rs1_data, 64'h0);
        reset = 1'b0;
        for (int i = 0; i < 127; i++) tick();
        check("reinit_ready_127", {63'b0, ready}, 64'h0);
        tick();
        check("reinit_ready_128", {63'b0, ready}, 64'h1);
        do_read(2'd0, 5'd1, 5'd9);
        check("reinit_t0_x1", rs1_data, 64'h0);
        check("reinit_t0_x9", rs2_data, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
